// File: rtl/mux_n_1_stream_if.sv
// Stream bus for the N:1 mux: N input channels plus one registered output.
// slave is the mux side, master is the producer/consumer side.
interface mux_n_1_stream_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = 2
);
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [SEL_W-1:0]   sel;
  logic               mode;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SEL_W-1:0]   out_ch;

  modport slave (
    input  in_data, in_valid, sel, mode, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );
  modport master (
    output in_data, in_valid, sel, mode, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );
endinterface

// File: rtl/mux_n_1_stream.sv
// N:1 stream mux with a single output register stage; manual select or
// round-robin arbitration, full 1 word/cycle throughput.
module mux_n_1_stream #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  mux_n_1_stream_if.slave     bus
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             slot_open;
  logic             chosen;
  logic [SEL_W-1:0] c;
  logic [WIDTH-1:0] c_data;
  logic             c_valid;
  logic             load;

  assign slot_open = ~out_valid_q | bus.out_ready;

  // Round-robin scan starts just past ptr, so ptr itself has lowest priority.
  always_comb begin
    int idx;
    idx    = 0;
    chosen = 1'b0;
    c      = '0;
    if (!bus.mode) begin
      if (int'(bus.sel) < N) begin
        chosen = 1'b1;
        c      = bus.sel;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= N) idx = idx - N;
        if (!chosen && bus.in_valid[idx]) begin
          chosen = 1'b1;
          c      = SEL_W'(idx);
        end
      end
    end
  end

  always_comb begin
    c_data  = '0;
    c_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (c == SEL_W'(i)) begin
        c_data  = bus.in_data[i*WIDTH +: WIDTH];
        c_valid = bus.in_valid[i];
      end
    end
  end

  assign load = slot_open & chosen & c_valid;

  for (genvar i = 0; i < N; i++) begin : g_rdy
    assign bus.in_ready[i] = rst_n & slot_open & chosen & (c == SEL_W'(i));
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = c_data;
      out_ch_d    = c;
      ptr_d       = c;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= SEL_W'(N-1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_n_1_stream.sv
// Bench for mux_n_1_stream: directed scenarios then random traffic, with a
// 4-channel and a 3-channel instance checked against a rule-level model.
module tb_mux_n_1_stream;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux_n_1_stream_if #(.WIDTH(8), .N(4), .SEL_W(2)) bus4 ();
  mux_n_1_stream_if #(.WIDTH(8), .N(3), .SEL_W(2)) bus3 ();

  mux_n_1_stream #(.WIDTH(8), .N(4), .SEL_W(2)) u4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  mux_n_1_stream #(.WIDTH(8), .N(3), .SEL_W(2)) u3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  typedef struct {
    bit       v;
    bit [7:0] d;
    bit [1:0] ch;
    int       ptr;
  } mst_t;

  mst_t m4, m3;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Channel picked this cycle, -1 when none.
  function automatic int choose(int n, bit mode, int sel, bit [3:0] iv, int ptr);
    if (!mode) return (sel < n) ? sel : -1;
    for (int k = 1; k <= n; k++) begin
      int j;
      j = (ptr + k) % n;
      if (iv[j]) return j;
    end
    return -1;
  endfunction

  function automatic bit [3:0] exp_rdy(mst_t m, int n, bit rst, bit mode, int sel,
                                       bit [3:0] iv, bit ordy);
    int c;
    c = choose(n, mode, sel, iv, m.ptr);
    if (!rst || (m.v && !ordy) || c < 0) return 4'b0;
    return 4'(1 << c);
  endfunction

  function automatic mst_t nxt(mst_t m, int n, bit rst, bit mode, int sel,
                               bit [3:0] iv, bit [31:0] dat, bit ordy);
    mst_t r;
    int   c;
    r = m;
    c = choose(n, mode, sel, iv, m.ptr);
    if (!rst) begin
      r.v = 0; r.d = 0; r.ch = 0; r.ptr = n - 1;
    end else if ((!m.v || ordy) && c >= 0 && iv[c]) begin
      r.v = 1; r.d = dat[c*8 +: 8]; r.ch = 2'(c); r.ptr = c;
    end else if (m.v && ordy) begin
      r.v = 0;
    end
    return r;
  endfunction

  task automatic step(input bit rst, input bit mode, input bit [1:0] sel,
                      input bit [3:0] iv, input bit [31:0] dat, input bit ordy);
    mst_t n4, n3;
    rst_n          = rst;
    bus4.mode      = mode;  bus3.mode      = mode;
    bus4.sel       = sel;   bus3.sel       = sel;
    bus4.in_valid  = iv;    bus3.in_valid  = iv[2:0];
    bus4.in_data   = dat;   bus3.in_data   = dat[23:0];
    bus4.out_ready = ordy;  bus3.out_ready = ordy;
    #1;
    chk("rdy4", 32'(bus4.in_ready), 32'(exp_rdy(m4, 4, rst, mode, sel, iv, ordy)));
    chk("rdy3", 32'(bus3.in_ready), 32'(exp_rdy(m3, 3, rst, mode, sel, {1'b0, iv[2:0]}, ordy) & 4'b0111));
    n4 = nxt(m4, 4, rst, mode, sel, iv, dat, ordy);
    n3 = nxt(m3, 3, rst, mode, sel, {1'b0, iv[2:0]}, {8'h0, dat[23:0]}, ordy);
    @(posedge clk);
    #1;
    m4 = n4;
    m3 = n3;
    chk("vld4", 32'(bus4.out_valid), 32'(m4.v));
    chk("dat4", 32'(bus4.out_data),  32'(m4.d));
    chk("ch4",  32'(bus4.out_ch),    32'(m4.ch));
    chk("vld3", 32'(bus3.out_valid), 32'(m3.v));
    chk("dat3", 32'(bus3.out_data),  32'(m3.d));
    chk("ch3",  32'(bus3.out_ch),    32'(m3.ch));
  endtask

  initial begin
    m4 = '{0, 0, 0, 3};
    m3 = '{0, 0, 0, 2};
    @(negedge clk);
    step(0, 0, 0, 4'h0, 32'h0, 1);
    step(0, 1, 0, 4'hF, 32'h0, 1);
    chk("rst_vld", 32'(bus4.out_valid), 32'h0);

    // Manual load of channel 2, then backpressure while ch2 changes.
    step(1, 0, 2, 4'b0100, 32'h00A5_0000, 1);
    chk("man_dat", 32'(bus4.out_data), 32'hA5);
    chk("man_ch",  32'(bus4.out_ch),   32'h2);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 2, 4'b0100, 32'h003C_0000, 0);
      chk("bp_hold", 32'(bus4.out_data), 32'hA5);
    end
    step(1, 0, 2, 4'b0100, 32'h003C_0000, 1);
    chk("bp_new", 32'(bus4.out_data), 32'h3C);

    // Hold 5A, then reset mid-stream.
    step(1, 0, 1, 4'b0010, 32'h0000_5A00, 1);
    step(1, 0, 1, 4'b0000, 32'h0, 0);
    chk("hold5a", 32'(bus4.out_data), 32'h5A);
    step(0, 1, 0, 4'hF, 32'h0, 0);
    chk("rst_dat", 32'(bus4.out_data), 32'h0);

    // Round-robin full load restarts at channel 0.
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 4'hF, 32'h4433_2211, 1);
      chk("rr_seq", 32'(bus4.out_ch), 32'(i % 4));
      chk("rr_vld", 32'(bus4.out_valid), 32'h1);
    end

    // Move ptr to 1, then sparse round-robin.
    step(1, 0, 1, 4'b0010, 32'h0000_7700, 1);
    step(1, 1, 0, 4'b1001, 32'hD000_00C0, 1);
    chk("sp_a", 32'(bus4.out_ch), 32'h3);
    step(1, 1, 0, 4'b1001, 32'hD000_00C0, 1);
    chk("sp_b", 32'(bus4.out_ch), 32'h0);
    step(1, 1, 0, 4'b1001, 32'hD000_00C0, 1);
    chk("sp_c", 32'(bus4.out_ch), 32'h3);

    // Out-of-range select on the 3-channel instance.
    step(1, 0, 0, 4'h0, 32'h0, 1);
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 3, 4'hF, 32'h0099_8877, 1);
      chk("bad_sel_vld", 32'(bus3.out_valid), 32'h0);
    end

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) != 0, 1'($urandom), 2'($urandom),
           4'($urandom), $urandom, $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
